// File: rtl/vga_timing_pkg.sv
// Shared timing constants and decode payload for the 640x480@60 VGA raster generator.
package vga_timing_pkg;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;

    localparam int unsigned H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned H_VIS_START = DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned H_VIS_END   = H_VIS_START + DEF_H_ACTIVE;
    localparam int unsigned V_VIS_START = DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned V_VIS_END   = V_VIS_START + DEF_V_ACTIVE;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned POS_W = 16;

    // Registered raster decodes, all derived from the next-state counters.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic frame_start;
    } vga_dec_t;

endpackage

// File: rtl/vga_timing_gen_pix_ce_div.sv
// Pixel clock-enable divider: one pix_ce pulse every CLK_DIV system clocks while ena is high.
module pix_ce_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic pix_ce
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;

    // Divider holds its phase while ena is low so resuming needs no resync.
    always_comb begin
        div_n = div;
        if (ena) begin
            div_n = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else begin
            div <= div_n;
        end
    end

    assign pix_ce = ena && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync/active/frame decodes.
// Build option VGA_SYNC_DELAY_EN adds one clk of delay to hsync/vsync only.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic             pix_ce,
    output logic [POS_W-1:0] posx,
    output logic [POS_W-1:0] posy,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             frame_start
);

    localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic [CNT_W-1:0] cnt_x;
    logic [CNT_W-1:0] cnt_y;
    logic [CNT_W-1:0] cnt_x_n;
    logic [CNT_W-1:0] cnt_y_n;
    vga_dec_t         dec;
    vga_dec_t         dec_n;

    pix_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_ce_div (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .pix_ce (pix_ce)
    );

    // Next raster position and decodes; decodes look at the next position so they align with it.
    always_comb begin
        cnt_x_n = cnt_x;
        cnt_y_n = cnt_y;
        dec_n   = '0;
        if (pix_ce) begin
            if (cnt_x == H_LAST) begin
                cnt_x_n = '0;
                cnt_y_n = (cnt_y == V_LAST) ? '0 : cnt_y + CNT_W'(1);
            end else begin
                cnt_x_n = cnt_x + CNT_W'(1);
            end
        end
        dec_n.hsync       = (cnt_x_n >= HS_END);
        dec_n.vsync       = (cnt_y_n >= VS_END);
        dec_n.active      = (cnt_x_n >= HA_START) && (cnt_x_n < HA_END) &&
                            (cnt_y_n >= VA_START) && (cnt_y_n < VA_END);
        dec_n.frame_start = pix_ce && (cnt_x == H_LAST) && (cnt_y == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_x <= '0;
            cnt_y <= '0;
            dec   <= '0;
        end else begin
            cnt_x <= cnt_x_n;
            cnt_y <= cnt_y_n;
            dec   <= dec_n;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hsync_d;
    logic vsync_d;

    // Extra stage lines syncs up with the renderer's registered RGB.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            hsync_d <= dec.hsync;
            vsync_d <= dec.vsync;
        end
    end

    assign hsync = hsync_d;
    assign vsync = vsync_d;
`else
    assign hsync = dec.hsync;
    assign vsync = dec.vsync;
`endif

    assign posx        = POS_W'(cnt_x);
    assign posy        = POS_W'(cnt_y);
    assign active      = dec.active;
    assign frame_start = dec.frame_start;

endmodule
